cmem_column_loader: RTL and testbench

Write-side loader for the compensation memory. Takes packed compensation columns of SIZE×4 bits from the pre-load unit over a valid/ready handshake. Serializes each column into SIZE single-nibble writes at column-interleaved addresses (addr = col + COLS·row). This is the exact inverse of the memory's packed column read. The block sits between the pre-load unit and the compensation memory's Wr_en/Wr_Addr/Compensation_Weight port, and signals completion so the controller can release Rd_en.

---
 rtl/cmem_pkg.sv | 23 ++
 rtl/cmem_col_serializer.sv | 47 ++++
 rtl/cmem_column_loader.sv | 113 +++++++++++
 tb/tb_cmem_column_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmem_pkg.sv
// Shared definitions for the compensation memory: loader FSM states,
// default array geometry and the memory depth/address-width derivation.
package cmem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_COL = 2'd1,
    SHIFT    = 2'd2,
    DONE     = 2'd3
  } cmem_state_e;

  localparam int SIZE_DEFAULT = 8;
  localparam int COLS_DEFAULT = 3;

  // Address width for a memory of the given depth in nibbles; never below 1.
  function automatic int cmem_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int CMEM_SIZE_DEFAULT       = SIZE_DEFAULT * COLS_DEFAULT;
  localparam int CMEM_ADDR_WIDTH_DEFAULT = cmem_addr_width(CMEM_SIZE_DEFAULT);

endpackage

// File: rtl/cmem_col_serializer.sv
// Column datapath: holds the packed column, its row index and the
// interleaved write address, and steps them one nibble per shift.
module cmem_col_serializer #(
  parameter int SIZE      = 8,
  parameter int COLS      = 3,
  parameter int ADDR_W    = 5,
  parameter int COL_WIDTH = SIZE * 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_shift,
  input  logic [COL_WIDTH-1:0] i_data,
  input  logic [ADDR_W-1:0]    i_col,
  output logic [3:0]           o_nibble,
  output logic [ADDR_W-1:0]    o_addr,
  output logic                 o_last_row
);

  localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [COL_WIDTH-1:0] r_shreg;
  logic [ROW_W-1:0]     r_row;
  logic [ADDR_W-1:0]    r_addr;

  // Load wins over shift so a back-to-back column reload restarts cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
      r_row   <= '0;
      r_addr  <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
      r_row   <= '0;
      r_addr  <= i_col;
    end else if (i_shift) begin
      r_shreg <= r_shreg >> 4;
      r_row   <= r_row + ROW_W'(1);
      r_addr  <= r_addr + ADDR_W'(COLS);
    end
  end

  assign o_nibble   = r_shreg[3:0];
  assign o_addr     = r_addr;
  assign o_last_row = (r_row == ROW_W'(SIZE - 1));

endmodule

// File: rtl/cmem_column_loader.sv
// Compensation memory write-side loader: serializes packed columns into
// column-interleaved nibble writes. Optional macro: CMEM_LOAD_PIPELINE_EN.
module cmem_column_loader
  import cmem_pkg::*;
#(
  parameter int SIZE            = SIZE_DEFAULT,
  parameter int COLS            = COLS_DEFAULT,
  parameter int CMEM_SIZE       = SIZE * COLS,
  parameter int CMEM_ADDR_WIDTH = cmem_addr_width(CMEM_SIZE),
  parameter int COL_WIDTH       = SIZE * 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       col_valid,
  output logic                       col_ready,
  input  logic [COL_WIDTH-1:0]       col_data,
  output logic [3:0]                 Compensation_Weight,
  output logic [CMEM_ADDR_WIDTH-1:0] Wr_Addr,
  output logic                       Wr_en,
  output logic                       busy,
  output logic                       done,
  output cmem_state_e                state_dbg
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  cmem_state_e          r_state;
  logic [COL_W-1:0]     r_col;

  logic                       w_in_shift;
  logic                       w_last_row;
  logic                       w_last_col;
  logic                       w_early_ready;
  logic                       w_hs;
  logic [CMEM_ADDR_WIDTH-1:0] w_load_col;
  logic [CMEM_ADDR_WIDTH-1:0] w_addr;
  logic [3:0]                 w_nibble;

  assign w_in_shift = (r_state == SHIFT);
  assign w_last_col = (r_col == COL_W'(COLS - 1));

`ifdef CMEM_LOAD_PIPELINE_EN
  assign w_early_ready = w_in_shift & w_last_row & ~w_last_col;
`else
  assign w_early_ready = 1'b0;
`endif

  // Handshake: a column transfers on any rising edge where col_valid and
  // col_ready are both high; col_ready depends only on registered state.
  assign col_ready  = (r_state == WAIT_COL) | w_early_ready;
  assign w_hs       = col_valid & col_ready;
  // A reload from SHIFT targets the next column, which r_col has not reached yet.
  assign w_load_col = CMEM_ADDR_WIDTH'(r_col) + CMEM_ADDR_WIDTH'(w_in_shift);

  cmem_col_serializer #(
    .SIZE      (SIZE),
    .COLS      (COLS),
    .ADDR_W    (CMEM_ADDR_WIDTH),
    .COL_WIDTH (COL_WIDTH)
  ) u_serializer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_hs),
    .i_shift    (w_in_shift & ~w_hs),
    .i_data     (col_data),
    .i_col      (w_load_col),
    .o_nibble   (w_nibble),
    .o_addr     (w_addr),
    .o_last_row (w_last_row)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_col   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= WAIT_COL;
            r_col   <= '0;
          end
        end
        WAIT_COL: begin
          if (w_hs) r_state <= SHIFT;
        end
        SHIFT: begin
          if (w_last_row) begin
            if (w_hs) begin
              r_col <= r_col + COL_W'(1);
            end else if (w_last_col) begin
              r_state <= DONE;
            end else begin
              r_col   <= r_col + COL_W'(1);
              r_state <= WAIT_COL;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Wr_en               = w_in_shift;
  assign Wr_Addr             = w_in_shift ? w_addr : '0;
  assign Compensation_Weight = w_in_shift ? w_nibble : 4'h0;
  assign busy                = (r_state != IDLE);
  assign done                = (r_state == DONE);
  assign state_dbg           = r_state;

endmodule

// File: tb/tb_cmem_column_loader.sv
// Directed bench for cmem_column_loader: write address/data/timing,
// handshake and done timing, stall, ignored start, and mid-load reset.
module tb_cmem_column_loader;
  import cmem_pkg::*;

  localparam int SIZE = 8;
  localparam int COLS = 3;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          col_valid = 1'b0;
  logic [31:0]   col_data = '0;
  logic          col_ready;
  logic [3:0]    cw;
  logic [AW-1:0] wa;
  logic          wr_en;
  logic          busy;
  logic          done;
  cmem_state_e   st;

  cmem_column_loader #(.SIZE(SIZE), .COLS(COLS)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .col_valid           (col_valid),
    .col_ready           (col_ready),
    .col_data            (col_data),
    .Compensation_Weight (cw),
    .Wr_Addr             (wa),
    .Wr_en               (wr_en),
    .busy                (busy),
    .done                (done),
    .state_dbg           (st)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  // Observed writes packed as {capture edge[15:0], addr[7:0], data[3:0]}.
  logic [27:0] obs_q[$];
  logic [27:0] exp_q[$];
  int          hs_q[$];
  int          done_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) obs_q.push_back({16'(edge_cnt + 1), 8'(wa), cw});
      if (col_valid && col_ready) hs_q.push_back(edge_cnt + 1);
      if (done) done_q.push_back(edge_cnt);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int t0;
  int exp_hs[3];
  int exp_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    exp_q.delete();
    hs_q.delete();
    done_q.delete();
  endtask

  // Present one column and hold col_valid until it is accepted.
  task automatic send_col(input logic [31:0] d);
    bit hs;
    col_data  = d;
    col_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      hs = col_ready;
      tick();
      if (hs) return;
    end
    check("send_col_timeout", 32'd1, 32'd0);
  endtask

  task automatic start_load(input logic [31:0] d0);
    col_data  = d0;
    col_valid = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    t0    = edge_cnt;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      tick();
    end
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_state_end"}, 32'(st), 32'(IDLE));
    check({tag, "_done_cnt"}, 32'(done_q.size()), 32'd1);
  endtask

  // Expected writes; the capture edge is only meaningful when timed=1.
  task automatic build_exp(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input bit timed);
    logic [31:0] d;
    for (int c = 0; c < COLS; c++) begin
      d = (c == 0) ? d0 : (c == 1) ? d1 : d2;
      for (int r = 0; r < SIZE; r++)
        exp_q.push_back({timed ? 16'(t0 + exp_hs[c] + 1 + r) : 16'd0,
                         8'(c + COLS * r), d[4*r +: 4]});
    end
  endtask

  task automatic compare_writes(input string tag, input bit timed);
    int n;
    check({tag, "_wr_cnt"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (timed)
        check($sformatf("%s_wr%0d_edge_addr_data", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
      else
        check($sformatf("%s_wr%0d_addr_data", tag, i), 32'(obs_q[i][11:0]), 32'(exp_q[i][11:0]));
    end
  endtask

  initial begin
`ifdef CMEM_LOAD_PIPELINE_EN
    exp_hs[0] = 1; exp_hs[1] = 9; exp_hs[2] = 17; exp_done = 25;
`else
    exp_hs[0] = 1; exp_hs[1] = 10; exp_hs[2] = 19; exp_done = 27;
`endif

    // Reset state
    #2 rst = 1'b1;
    repeat (3) tick();
    check("rst_col_ready", 32'(col_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wa), 32'd0);
    check("rst_weight", 32'(cw), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(st), 32'(IDLE));
    rst = 1'b0;
    tick();

    // col_valid with no load in progress
    clear_obs();
    col_valid = 1'b1;
    col_data  = 32'h12345678;
    repeat (5) tick();
    check("idle_col_ready", 32'(col_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_writes", 32'(obs_q.size()), 32'd0);
    check("idle_hs", 32'(hs_q.size()), 32'd0);
    col_valid = 1'b0;

    // Full load, col_valid held high
    clear_obs();
    start_load(32'h87654321);
    check("main_ready_after_start", 32'(col_ready), 32'd1);
    send_col(32'h87654321);
    send_col(32'hFEDCBA98);
    send_col(32'h0F0F0F0F);
    wait_idle("main");
    check("main_hs_cnt", 32'(hs_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < hs_q.size(); i++)
      check($sformatf("main_hs%0d_edge", i), 32'(hs_q[i] - t0), 32'(exp_hs[i]));
    if (done_q.size() > 0) check("main_done_edge", 32'(done_q[0] - t0), 32'(exp_done));
    build_exp(32'h87654321, 32'hFEDCBA98, 32'h0F0F0F0F, 1'b1);
    compare_writes("main", 1'b1);
    col_valid = 1'b0;
    tick();

    // Stall before column 1
    clear_obs();
    start_load(32'hA5A5A5A5);
    send_col(32'hA5A5A5A5);
    col_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (st == WAIT_COL) break;
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_wr_en", k), 32'(wr_en), 32'd0);
      check($sformatf("stall%0d_busy", k), 32'(busy), 32'd1);
      tick();
    end
    send_col(32'h13579BDF);
    send_col(32'h2468ACE0);
    wait_idle("stall");
    build_exp(32'hA5A5A5A5, 32'h13579BDF, 32'h2468ACE0, 1'b0);
    compare_writes("stall", 1'b0);
    col_valid = 1'b0;
    tick();

    // start pulsed during SHIFT is ignored
    clear_obs();
    start_load(32'h11223344);
    send_col(32'h11223344);
    repeat (2) tick();
    check("ign_state_shift", 32'(st), 32'(SHIFT));
    start = 1'b1;
    tick();
    start = 1'b0;
    send_col(32'h55667788);
    send_col(32'h99AABBCC);
    wait_idle("ign");
    build_exp(32'h11223344, 32'h55667788, 32'h99AABBCC, 1'b0);
    compare_writes("ign", 1'b0);
    col_valid = 1'b0;
    tick();

    // Reset after the 4th write of column 1
    clear_obs();
    start_load(32'hDEADBEEF);
    send_col(32'hDEADBEEF);
    send_col(32'hCAFEF00D);
    for (int i = 0; i < 200; i++) begin
      if (obs_q.size() >= 12) break;
      tick();
    end
    check("mid_writes_before_rst", 32'(obs_q.size()), 32'd12);
    check("mid_wr_en_before_rst", 32'(wr_en), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_wr_addr", 32'(wa), 32'd0);
    check("mid_rst_weight", 32'(cw), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_col_ready", 32'(col_ready), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_state", 32'(st), 32'(IDLE));
    col_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    clear_obs();
    start_load(32'h76543210);
    send_col(32'h76543210);
    send_col(32'h0123ABCD);
    send_col(32'hF0E1D2C3);
    wait_idle("post_rst");
    build_exp(32'h76543210, 32'h0123ABCD, 32'hF0E1D2C3, 1'b1);
    compare_writes("post_rst", 1'b1);
    col_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
